// File: rtl/tl_ul_ram_slave_if.sv
// TileLink-UL A/D channel bundle between an interconnect master port and a
// memory slave. Only the channels a UL slave needs (A and D) are present.
interface tl_ul_ram_slave_if #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int SZW = 3,
  parameter int AIW = 4,
  parameter int DIW = 1
);
  localparam int BEW = DW / 8;

  // Channel A: request
  logic           a_valid;
  logic           a_ready;
  logic [2:0]     a_opcode;
  logic [2:0]     a_param;
  logic [SZW-1:0] a_size;
  logic [AIW-1:0] a_source;
  logic [AW-1:0]  a_address;
  logic [BEW-1:0] a_mask;
  logic [DW-1:0]  a_data;
  logic           a_corrupt;

  // Channel D: response
  logic           d_valid;
  logic           d_ready;
  logic [3:0]     d_opcode;
  logic [1:0]     d_param;
  logic [SZW-1:0] d_size;
  logic [AIW-1:0] d_source;
  logic [DIW-1:0] d_sink;
  logic           d_denied;
  logic [DW-1:0]  d_data;
  logic           d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_ul_ram_slave.sv
// TileLink-UL single-beat RAM slave. Accepts Get / PutFullData /
// PutPartialData on channel A, executes against a synchronous-read RAM and
// answers with exactly one channel D beat per request. One request is in
// flight at a time; the IDLE/READ/RESP FSM back-pressures channel A.
module tl_ul_ram_slave #(
  parameter int             AW      = 32,
  parameter int             DW      = 64,
  parameter int             SZW     = 3,
  parameter int             AIW     = 4,
  parameter int             DIW     = 1,
  parameter int             DEPTH   = 256,
  parameter logic [AW-1:0]  BASE    = AW'(32'h0000_0000),
  parameter int             SINK_ID = 0
) (
  input logic                clk,
  input logic                rst_n,
  tl_ul_ram_slave_if.slave   bus
);

  localparam int BEW  = DW / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int IDXW = $clog2(DEPTH);

  // Size of the decoded window in bytes, one bit wider than the address so
  // the upper-bound compare cannot wrap.
  localparam logic [AW:0]     SPAN     = (AW+1)'(DEPTH * BEW);
  localparam logic [SZW-1:0]  MAX_SIZE = SZW'(OFFW);
  localparam logic [OFFW-1:0] ONES     = '1;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  localparam logic [3:0] D_ACK       = 4'd0;
  localparam logic [3:0] D_ACK_DATA  = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Request decode
  logic            a_ready;
  logic            fire;
  logic            is_get;
  logic            is_put;
  logic            deny;
  logic            wr_en;
  logic [IDXW-1:0] idx_a;

  // Response registers
  logic [3:0]      d_opcode_q;
  logic [SZW-1:0]  d_size_q;
  logic [AIW-1:0]  d_source_q;
  logic            d_denied_q;
  logic            d_corrupt_q;
  logic            use_ram_q;

  // Storage
  logic [DW-1:0]   mem [DEPTH];
  logic [IDXW-1:0] idx_q;
  logic [DW-1:0]   rd_data_q;

  // a_param carries no meaning for UL access ops; a_corrupt on a Put still
  // stores the data unchanged, so neither affects behaviour.
  logic unused_ok;
  assign unused_ok = ^{bus.a_param, bus.a_corrupt};

  // Any one failing check rejects the request: unknown opcode, a size wider
  // than a beat, an address not aligned to its size, or outside the window.
  function automatic logic calc_deny(input logic [2:0]     op,
                                     input logic [SZW-1:0] sz,
                                     input logic [AW-1:0]  addr);
    logic            bad_op;
    logic            bad_size;
    logic            bad_align;
    logic            bad_range;
    logic [OFFW-1:0] lsb_mask;
    logic [AW:0]     offset;
    bad_op    = !((op == OP_PUT_FULL) || (op == OP_PUT_PART) || (op == OP_GET));
    bad_size  = (sz > MAX_SIZE);
    lsb_mask  = ~(ONES << sz);
    bad_align = ((addr[OFFW-1:0] & lsb_mask) != '0);
    offset    = {1'b0, addr} - {1'b0, BASE};
    bad_range = (addr < BASE) || (offset >= SPAN);
    return bad_op || bad_size || bad_align || bad_range;
  endfunction

  assign is_get = (bus.a_opcode == OP_GET);
  assign is_put = (bus.a_opcode == OP_PUT_FULL) || (bus.a_opcode == OP_PUT_PART);
  assign deny   = calc_deny(bus.a_opcode, bus.a_size, bus.a_address);
  assign idx_a  = bus.a_address[OFFW +: IDXW];
  assign fire   = bus.a_valid && a_ready;
  assign wr_en  = fire && is_put && !deny;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and channel A back-pressure; ready is held low in reset
  always_comb begin
    state_d = state_q;
    a_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        a_ready = rst_n;
        if (bus.a_valid && rst_n) begin
          state_d = (is_get && !deny) ? READ : RESP;
        end
      end
      READ: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.d_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response header: captured on accept, held until the D handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_opcode_q  <= D_ACK;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      use_ram_q   <= 1'b0;
    end else if (fire) begin
      d_opcode_q  <= is_get ? D_ACK_DATA : D_ACK;
      d_size_q    <= bus.a_size;
      d_source_q  <= bus.a_source;
      d_denied_q  <= deny;
      d_corrupt_q <= deny && is_get;
      use_ram_q   <= 1'b0;
    end else if (state_q == READ) begin
      use_ram_q   <= 1'b1;
    end
  end

  // Word index of the accepted request, used by the read in the READ cycle
  always_ff @(posedge clk) begin
    if (fire) begin
      idx_q <= idx_a;
    end
  end

  // Byte-masked write on the accept cycle; masked-off lanes keep their value
  always_ff @(posedge clk) begin
    for (int b = 0; b < BEW; b++) begin
      if (wr_en && bus.a_mask[b]) begin
        mem[idx_a][8*b +: 8] <= bus.a_data[8*b +: 8];
      end
    end
  end

  // Synchronous RAM read, performed only in the READ cycle
  always_ff @(posedge clk) begin
    if (state_q == READ) begin
      rd_data_q <= mem[idx_q];
    end
  end

  assign bus.a_ready   = a_ready;
  assign bus.d_valid   = (state_q == RESP);
  assign bus.d_opcode  = d_opcode_q;
  assign bus.d_param   = 2'b00;
  assign bus.d_size    = d_size_q;
  assign bus.d_source  = d_source_q;
  assign bus.d_sink    = DIW'(SINK_ID);
  assign bus.d_denied  = d_denied_q;
  assign bus.d_corrupt = d_corrupt_q;
  // Read data is only presented for a successful Get; everything else is 0
  assign bus.d_data    = use_ram_q ? rd_data_q : '0;

endmodule

// File: tb/tb_tl_ul_ram_slave.sv
// Directed bench for tl_ul_ram_slave: Put/Get data path, partial writes,
// deny cases, D-channel stall and asynchronous reset during a response.
module tb_tl_ul_ram_slave;

  localparam int AW = 32, DW = 64, SZW = 3, AIW = 4, DIW = 1, DEPTH = 256;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  tl_ul_ram_slave_if #(.AW(AW), .DW(DW), .SZW(SZW), .AIW(AIW), .DIW(DIW)) bus ();

  tl_ul_ram_slave #(
    .AW(AW), .DW(DW), .SZW(SZW), .AIW(AIW), .DIW(DIW),
    .DEPTH(DEPTH), .BASE(32'h0000_0000), .SINK_ID(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request while the slave is idle; returns 1 ns after the
  // accepting edge with a_valid already dropped.
  task automatic send(input string tag, input logic [2:0] op, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic [3:0] src);
    chk({tag, ".a_ready"}, 64'(bus.a_ready), 64'd1);
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_size    = sz;
    bus.a_address = addr;
    bus.a_mask    = mask;
    bus.a_data    = data;
    bus.a_source  = src;
    step();
    bus.a_valid   = 1'b0;
  endtask

  // Check the pending D beat, then complete the handshake
  task automatic resp(input string tag, input logic [3:0] op, input logic [3:0] src,
                      input logic den, input logic cor, input logic [63:0] data);
    chk({tag, ".d_valid"},   64'(bus.d_valid),   64'd1);
    chk({tag, ".d_opcode"},  64'(bus.d_opcode),  64'(op));
    chk({tag, ".d_source"},  64'(bus.d_source),  64'(src));
    chk({tag, ".d_denied"},  64'(bus.d_denied),  64'(den));
    chk({tag, ".d_corrupt"}, 64'(bus.d_corrupt), 64'(cor));
    chk({tag, ".d_data"},    bus.d_data,         data);
    chk({tag, ".a_ready_busy"}, 64'(bus.a_ready), 64'd0);
    bus.d_ready = 1'b1;
    step();
    bus.d_ready = 1'b0;
    chk({tag, ".d_valid_done"}, 64'(bus.d_valid), 64'd0);
    chk({tag, ".a_ready_back"}, 64'(bus.a_ready), 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.a_opcode = 3'd0; bus.a_param = 3'd0; bus.a_size = 3'd0;
    bus.a_source = 4'd0; bus.a_address = 32'd0; bus.a_mask = 8'd0; bus.a_data = 64'd0;
    bus.a_corrupt = 1'b0; bus.d_ready = 1'b0;

    // Reset state
    #1;
    chk("rst.a_ready",   64'(bus.a_ready),   64'd0);
    chk("rst.d_valid",   64'(bus.d_valid),   64'd0);
    chk("rst.d_opcode",  64'(bus.d_opcode),  64'd0);
    chk("rst.d_size",    64'(bus.d_size),    64'd0);
    chk("rst.d_source",  64'(bus.d_source),  64'd0);
    chk("rst.d_denied",  64'(bus.d_denied),  64'd0);
    chk("rst.d_corrupt", 64'(bus.d_corrupt), 64'd0);
    chk("rst.d_data",    bus.d_data,         64'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst.a_ready_release", 64'(bus.a_ready), 64'd1);
    chk("rst.d_sink",  64'(bus.d_sink),  64'd0);
    chk("rst.d_param", 64'(bus.d_param), 64'd0);

    // PutFullData then Get at 0x8
    send("put1", 3'd0, 3'd3, 32'h8, 8'hFF, 64'h1122334455667788, 4'd3);
    chk("put1.d_size", 64'(bus.d_size), 64'd3);
    resp("put1", 4'd0, 4'd3, 1'b0, 1'b0, 64'd0);
    send("get1", 3'd4, 3'd3, 32'h8, 8'h00, 64'd0, 4'd7);
    chk("get1.lat1", 64'(bus.d_valid), 64'd0);
    step();
    resp("get1", 4'd1, 4'd7, 1'b0, 1'b0, 64'h1122334455667788);

    // PutPartialData on the low four lanes, then read back
    send("putp", 3'd1, 3'd3, 32'h8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 4'd2);
    resp("putp", 4'd0, 4'd2, 1'b0, 1'b0, 64'd0);
    send("getp", 3'd4, 3'd3, 32'h8, 8'h00, 64'd0, 4'd2);
    chk("getp.lat1", 64'(bus.d_valid), 64'd0);
    step();
    resp("getp", 4'd1, 4'd2, 1'b0, 1'b0, 64'h11223344BBBBBBBB);

    // Last word of the window
    send("put_top", 3'd0, 3'd3, 32'h7F8, 8'hFF, 64'hDEADBEEF_01234567, 4'd9);
    resp("put_top", 4'd0, 4'd9, 1'b0, 1'b0, 64'd0);
    send("get_top", 3'd4, 3'd3, 32'h7F8, 8'h00, 64'd0, 4'd9);
    step();
    resp("get_top", 4'd1, 4'd9, 1'b0, 1'b0, 64'hDEADBEEF_01234567);

    // Word 0 shares its index with the out-of-range address 0x800
    send("put_w0", 3'd0, 3'd3, 32'h0, 8'hFF, 64'h0F0E0D0C0B0A0908, 4'd1);
    resp("put_w0", 4'd0, 4'd1, 1'b0, 1'b0, 64'd0);

    // Out-of-range Get: one-cycle latency, denied and corrupt
    send("get_oor", 3'd4, 3'd3, 32'h800, 8'hFF, 64'd0, 4'd5);
    resp("get_oor", 4'd1, 4'd5, 1'b1, 1'b1, 64'd0);
    // Out-of-range Put must not alias onto word 0
    send("put_oor", 3'd0, 3'd3, 32'h800, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 4'd5);
    resp("put_oor", 4'd0, 4'd5, 1'b1, 1'b0, 64'd0);
    send("get_w0", 3'd4, 3'd3, 32'h0, 8'h00, 64'd0, 4'd1);
    step();
    resp("get_w0", 4'd1, 4'd1, 1'b0, 1'b0, 64'h0F0E0D0C0B0A0908);

    // Misaligned 4-byte Get, aligned 4-byte Get, oversize Get, bad opcode
    send("get_mis", 3'd4, 3'd2, 32'h2, 8'h00, 64'd0, 4'd4);
    resp("get_mis", 4'd1, 4'd4, 1'b1, 1'b1, 64'd0);
    send("get_al4", 3'd4, 3'd2, 32'hC, 8'h00, 64'd0, 4'd6);
    chk("get_al4.lat1", 64'(bus.d_valid), 64'd0);
    step();
    chk("get_al4.d_size", 64'(bus.d_size), 64'd2);
    resp("get_al4", 4'd1, 4'd6, 1'b0, 1'b0, 64'h11223344BBBBBBBB);
    send("get_big", 3'd4, 3'd4, 32'h0, 8'h00, 64'd0, 4'd8);
    resp("get_big", 4'd1, 4'd8, 1'b1, 1'b1, 64'd0);
    send("bad_op", 3'd2, 3'd3, 32'h8, 8'hFF, 64'h5555555555555555, 4'd10);
    resp("bad_op", 4'd0, 4'd10, 1'b1, 1'b0, 64'd0);

    // D-channel stall: response must hold and A must stay blocked
    send("stall", 3'd0, 3'd3, 32'h18, 8'hFF, 64'h0123456789ABCDEF, 4'd12);
    bus.a_valid  = 1'b1;
    bus.a_opcode = 3'd4;
    bus.a_source = 4'd1;
    for (int i = 0; i < 5; i++) begin
      chk("stall.d_valid",  64'(bus.d_valid),  64'd1);
      chk("stall.a_ready",  64'(bus.a_ready),  64'd0);
      chk("stall.d_source", 64'(bus.d_source), 64'd12);
      chk("stall.d_opcode", 64'(bus.d_opcode), 64'd0);
      chk("stall.d_denied", 64'(bus.d_denied), 64'd0);
      step();
    end
    bus.a_valid = 1'b0;
    resp("stall", 4'd0, 4'd12, 1'b0, 1'b0, 64'd0);

    // Asynchronous reset while a response is pending
    send("rst_mid", 3'd0, 3'd3, 32'h10, 8'hFF, 64'hCAFEF00D_12345678, 4'd11);
    chk("rst_mid.d_valid_pre", 64'(bus.d_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.d_valid", 64'(bus.d_valid), 64'd0);
    chk("rst_mid.a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_mid.d_source", 64'(bus.d_source), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_mid.a_ready_release", 64'(bus.a_ready), 64'd1);
    chk("rst_mid.d_valid_release", 64'(bus.d_valid), 64'd0);
    step();
    chk("rst_mid.idle_hold", 64'(bus.d_valid), 64'd0);
    send("get_rst", 3'd4, 3'd3, 32'h10, 8'h00, 64'd0, 4'd11);
    chk("get_rst.lat1", 64'(bus.d_valid), 64'd0);
    step();
    resp("get_rst", 4'd1, 4'd11, 1'b0, 1'b0, 64'hCAFEF00D_12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tl_ul_ram_slave.md
Name: tl_ul_ram_slave

Overview:
- TileLink-UL single-beat memory slave that terminates the slave port of the TileLink interconnect (the L2-side endpoint).
- Consumes Channel A requests (Get, PutFullData, PutPartialData) and executes them against an internal synchronous-read RAM.
- Returns exactly one Channel D response per accepted request, with source echo.
- One request outstanding at a time; a 3-state FSM provides back-pressure.

Parameters:
- AW, 32, address width
- DW, 64, data width; BEW = DW/8 byte lanes
- SZW, 3, a_size/d_size width
- AIW, 4, source ID width
- DIW, 1, sink ID width
- DEPTH, 256, RAM words (power of 2)
- BASE, 32'h0000_0000, byte base address; must be aligned to DEPTH*BEW
- SINK_ID, 0, constant driven on d_sink

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- a_valid  in  1  request valid
- a_ready  out  1  request accepted when a_valid & a_ready
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_param  in  3  ignored
- a_size  in  SZW  log2 bytes
- a_source  in  AIW  request ID
- a_address  in  AW  byte address
- a_mask  in  BEW  byte enables
- a_data  in  DW  write data
- a_corrupt  in  1  write data corrupt
- d_valid  out  1  response valid
- d_ready  in  1  response accepted when d_valid & d_ready
- d_opcode  out  4  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  SZW  echo of a_size
- d_source  out  AIW  echo of a_source
- d_sink  out  DIW  SINK_ID
- d_denied  out  1  request rejected
- d_data  out  DW  read data (0 for AccessAck)
- d_corrupt  out  1  response data corrupt

Behaviour:
- Reset is asynchronous and active-low on rst_n; all state is clocked on clk.
- Reset values: FSM=IDLE, d_valid=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_data=0, d_corrupt=0. a_ready=0 while rst_n=0. RAM contents are not reset.
- FSM states:
  - IDLE: a_ready=1. On fire, capture source, size and opcode, and compute deny. Go to READ if the request is a Get and not denied; otherwise go to RESP.
  - READ: a_ready=0. The RAM read occurs this cycle; go to RESP with d_data loaded from the RAM output.
  - RESP: d_valid=1 and a_ready=0. When d_ready=1, go to IDLE.
- d_* outputs are registered and hold stable while d_valid=1 and d_ready=0.
- Latency, fire to d_valid:
  - Put: 1 cycle.
  - Get: 2 cycles.
  - Denied request: 1 cycle.
- Minimum request period is 2 cycles for Put and 3 for Get. There is no A/D overlap: the next request is accepted only in the cycle after the D handshake.
- Word index = a_address[log2(BEW) +: log2(DEPTH)].
- Deny conditions (any one sets the request as denied):
  - a_opcode not in {0,1,4};
  - a_size > log2(BEW);
  - a_address[log2(BEW)-1:0] not aligned to 2^a_size;
  - a_address < BASE or a_address >= BASE + DEPTH*BEW (computed without overflow).
- Put, not denied:
  - Write on the fire cycle into the byte lanes where a_mask=1; lanes with mask 0 are unchanged.
  - a_corrupt=1 still performs the write (data is stored as-is).
  - Response: AccessAck, denied=0, corrupt=0, data=0.
- Get, not denied:
  - Response: AccessAckData with the full DW word, denied=0, corrupt=0.
  - a_mask is ignored for Gets.
- Denied requests:
  - No RAM write.
  - Get: AccessAckData with denied=1, corrupt=1, data=0.
  - Put: AccessAck with denied=1, corrupt=0.
  - An unsupported opcode is answered with AccessAck, denied=1.
- Read-after-write: a Get following a Put to the same word returns the new data, since the write completes before the Get can be accepted.
- Reset mid-operation: the in-flight response is dropped and d_valid is cleared immediately. A write that already fired stays written.
- Channels B, C and E are not implemented.

Test Plan:
- PutFullData addr=BASE+0x8, size=3, mask=0xFF, data=0x1122334455667788, source=3 -> d_valid one cycle after fire: opcode=0, source=3, denied=0. Then Get at the same address -> d_valid 2 cycles after fire: opcode=1, data=0x1122334455667788.
- PutPartialData addr=BASE+0x8, mask=0x0F, data=0xAAAAAAAA_BBBBBBBB, then Get -> data=0x11223344BBBBBBBB.
- Get at addr=BASE+DEPTH*8 (out of range), source=5 -> opcode=1, denied=1, corrupt=1, data=0, source=5. Put at the same address -> opcode=0, denied=1, and no word in the RAM changes.
- Get with size=2 at addr=BASE+0x2 (misaligned) -> denied=1. a_opcode=2 -> AccessAck with denied=1.
- Hold d_ready=0 for 5 cycles during RESP -> d_valid stays 1, all d_* stable, a_ready=0 throughout. Raise d_ready -> a_ready=1 in the next cycle.
- Drive rst_n low while in RESP -> d_valid=0 and a_ready=0 immediately (asynchronous). After release, a_ready=1 and the FSM is in IDLE.
